// File: rtl/mgt_01_fp_round_unit_pkg.sv
// Shared types and constants for the FP rounding unit: float layout, rounding
// modes, exception flags and the overflow-result selection helper.
package mgt_01_fp_round_unit_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_t;

  typedef enum logic {
    FU_FREE = 1'b0,
    FU_BUSY = 1'b1
  } fu_state_e;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } round_mode_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  localparam logic [31:0] CANONICAL_NAN = 32'h7FC0_0000;
  localparam logic [31:0] MAX_FINITE    = 32'h7F7F_FFFF;
  localparam logic [7:0]  EXP_ALL_ONES  = 8'hFF;

  // Overflow saturates to inf or the largest finite value depending on the
  // direction the rounding mode pushes the magnitude.
  function automatic float_t overflow_result(input logic s, input logic [2:0] rm);
    float_t inf_v;
    float_t max_v;
    inf_v      = '0;
    inf_v.sign = s;
    inf_v.exp  = EXP_ALL_ONES;
    max_v      = float_t'(MAX_FINITE);
    max_v.sign = s;
    case (rm)
      RM_RTZ:  return max_v;
      RM_RDN:  return s ? inf_v : max_v;
      RM_RUP:  return s ? max_v : inf_v;
      default: return inf_v;
    endcase
  endfunction

endpackage

// File: rtl/mgt_01_fp_round_unit_round_decision.sv
// Combinational rounding decision: increment, inexact and illegal-mode detect
// from sign, mantissa LSB, guard/round/sticky and the rounding mode.
module mgt_01_round_decision
  import mgt_01_fp_round_unit_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic [2:0] grs,
  input  logic [2:0] rm,
  output logic       inc,
  output logic       inexact,
  output logic       rm_invalid
);

  logic g;
  logic rs;

  assign g       = grs[2];
  assign rs      = |grs[1:0];
  assign inexact = |grs;

  always_comb begin
    inc        = 1'b0;
    rm_invalid = 1'b0;
    case (rm)
      RM_RNE:  inc = g & (rs | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & inexact;
      RM_RUP:  inc = ~sign & inexact;
      RM_RMM:  inc = g;
      default: rm_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/mgt_01_fp_round_unit.sv
// FP round unit: IDLE -> ROUND -> (RENORM) -> VALID sequencer around the
// rounding decision. Define FP_FLUSH_TO_ZERO_EN to flush subnormal results to zero.
module mgt_01_fp_round_unit
  import mgt_01_fp_round_unit_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      clk_en_i,
  input  float_t    to_round_i,
  input  logic [2:0] grs_i,
  input  logic [2:0] round_mode_i,
  input  logic      valid_i,
  input  logic      overflow_i,
  input  logic      underflow_i,
  input  logic      invalid_op_i,
  output float_t    result_o,
  output logic      valid_o,
  output fu_state_e fu_state_o,
  output fflags_t   fflags_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROUND  = 2'd1;
  localparam logic [1:0] S_RENORM = 2'd2;
  localparam logic [1:0] S_VALID  = 2'd3;

  logic [1:0]  state;
  logic        sign_q;
  logic [7:0]  exp_q;
  logic [22:0] mant_q;
  logic [2:0]  grs_q;
  logic [2:0]  rm_q;
  logic        ovf_q;
  logic        udf_q;
  logic        inv_q;
  logic        nx_q;

  logic        inc;
  logic        nx;
  logic        rm_bad;
  logic [23:0] mant_sum;
  logic [8:0]  exp_inc;

  logic [7:0]  fin_exp;
  logic [22:0] fin_mant;
  logic        fin_nx;
  float_t      fin_res;
  fflags_t     fin_flags;
  fflags_t     ovf_flags;

  mgt_01_round_decision u_dec (
    .sign       (sign_q),
    .lsb        (mant_q[0]),
    .grs        (grs_q),
    .rm         (rm_q),
    .inc        (inc),
    .inexact    (nx),
    .rm_invalid (rm_bad)
  );

  assign mant_sum   = {1'b0, mant_q} + {23'd0, inc};
  assign exp_inc    = {1'b0, exp_q} + 9'd1;
  assign fu_state_o = (state == S_IDLE) ? FU_FREE : FU_BUSY;

  always_comb begin
    ovf_flags    = '0;
    ovf_flags.of = 1'b1;
    ovf_flags.nx = 1'b1;
  end

  // Final packing shared by the no-carry ROUND exit and the RENORM exit.
  always_comb begin
    if (state == S_RENORM) begin
      fin_exp  = exp_inc[7:0];
      fin_mant = mant_q;
      fin_nx   = nx_q;
    end else begin
      fin_exp  = exp_q;
      fin_mant = mant_sum[22:0];
      fin_nx   = nx;
    end
    fin_res      = {sign_q, fin_exp, fin_mant};
    fin_flags    = '0;
    fin_flags.nx = fin_nx;
    fin_flags.uf = udf_q | ((fin_exp == 8'd0) & fin_nx);
`ifdef FP_FLUSH_TO_ZERO_EN
    if (fin_exp == 8'd0 && fin_mant != 23'd0) begin
      fin_res.mant = '0;
      fin_flags.uf = 1'b1;
      fin_flags.nx = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      result_o <= '0;
      fflags_o <= '0;
      valid_o  <= 1'b0;
    end else if (clk_en_i) begin
      valid_o <= 1'b0;
      case (state)
        S_IDLE: if (valid_i) begin
          sign_q <= to_round_i.sign;
          exp_q  <= to_round_i.exp;
          mant_q <= to_round_i.mant;
          grs_q  <= grs_i;
          rm_q   <= round_mode_i;
          ovf_q  <= overflow_i;
          udf_q  <= underflow_i;
          inv_q  <= invalid_op_i;
          state  <= S_ROUND;
        end
        S_ROUND: begin
          state   <= S_VALID;
          valid_o <= 1'b1;
          if (inv_q || rm_bad) begin
            result_o    <= float_t'(CANONICAL_NAN);
            fflags_o    <= '0;
            fflags_o.nv <= 1'b1;
          end else if (ovf_q) begin
            result_o <= overflow_result(sign_q, rm_q);
            fflags_o <= ovf_flags;
          end else if (exp_q == EXP_ALL_ONES) begin
            result_o    <= {sign_q, exp_q, mant_q};
            fflags_o    <= '0;
            fflags_o.uf <= udf_q;
          end else if (mant_sum[23]) begin
            // Carry out of the mantissa: defer the exponent bump a cycle.
            mant_q  <= mant_sum[22:0];
            nx_q    <= nx;
            state   <= S_RENORM;
            valid_o <= 1'b0;
          end else begin
            result_o <= fin_res;
            fflags_o <= fin_flags;
          end
        end
        S_RENORM: begin
          state   <= S_VALID;
          valid_o <= 1'b1;
          if (exp_inc[8] || exp_inc[7:0] == EXP_ALL_ONES) begin
            result_o <= overflow_result(sign_q, rm_q);
            fflags_o <= ovf_flags;
          end else begin
            result_o <= fin_res;
            fflags_o <= fin_flags;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mgt_01_fp_round_unit.sv
// Scoreboard bench for the FP round unit: expectations queued at drive time,
// checked (value, flags, latency) when valid_o pulses.
module tb_mgt_01_fp_round_unit;
  import mgt_01_fp_round_unit_pkg::*;

  logic        clk_i    = 1'b0;
  logic        rst_i    = 1'b1;
  logic        clk_en_i = 1'b0;
  logic        valid_i  = 1'b0;
  logic        ovf      = 1'b0;
  logic        udf      = 1'b0;
  logic        inv      = 1'b0;
  logic [31:0] to_round = '0;
  logic [2:0]  grs      = '0;
  logic [2:0]  rm       = '0;
  logic [31:0] result;
  logic        valid_o;
  fu_state_e   fu_state;
  logic [4:0]  fflags;

  always #5 clk_i = ~clk_i;

  mgt_01_fp_round_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clk_en_i     (clk_en_i),
    .to_round_i   (to_round),
    .grs_i        (grs),
    .round_mode_i (rm),
    .valid_i      (valid_i),
    .overflow_i   (ovf),
    .underflow_i  (udf),
    .invalid_op_i (inv),
    .result_o     (result),
    .valid_o      (valid_o),
    .fu_state_o   (fu_state),
    .fflags_o     (fflags)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   n_valid = 0;
  int   n_sent  = 0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin
    if (valid_o === 1'b1) begin
      n_valid++;
      if (sb.size() == 0) chk("unexpected_valid", 32'(valid_o), 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("result", result, mon_e.res);
        chk("fflags", 32'(fflags), 32'(mon_e.fl));
        chk("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
      end
    end
  end

  task automatic push_exp(input logic [31:0] er, input logic [4:0] ef, input int lat);
    exp_t e;
    e.res = er; e.fl = ef; e.lat = lat; e.t0 = cyc;
    sb.push_back(e);
    n_sent++;
  endtask

  task automatic wait_drain();
    int budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk_i);
      budget--;
    end
    if (sb.size() != 0) begin
      chk("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] g, input logic [2:0] m,
                      input logic o, input logic u, input logic iv,
                      input logic [31:0] er, input logic [4:0] ef, input int lat, input int stall);
    @(negedge clk_i);
    to_round = d; grs = g; rm = m; ovf = o; udf = u; inv = iv; valid_i = 1'b1;
    push_exp(er, ef, lat + stall);
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    if (stall > 0) begin
      clk_en_i = 1'b0;
      repeat (stall) @(posedge clk_i);
      #1 clk_en_i = 1'b1;
    end
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset with clock enable low: reset must still take effect.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_result", result, 32'd0);
    chk("rst_fflags", 32'(fflags), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_fu_state", 32'(fu_state), 32'(FU_FREE));
    rst_i = 1'b0; clk_en_i = 1'b1;

    // Basic RNE, carry/RENORM, overflow by carry, RTZ saturation.
    send(32'h3F800001, 3'b100, RM_RNE, 0, 0, 0, 32'h3F800002, 5'b00001, 2, 0);
    send(32'h3F800000, 3'b100, RM_RNE, 0, 0, 0, 32'h3F800000, 5'b00001, 2, 0);
    send(32'h3F800000, 3'b110, RM_RNE, 0, 0, 0, 32'h3F800001, 5'b00001, 2, 0);
    send(32'h3F7FFFFF, 3'b110, RM_RNE, 0, 0, 0, 32'h3F800000, 5'b00001, 3, 0);
    send(32'h7F7FFFFF, 3'b111, RM_RUP, 0, 0, 0, 32'h7F800000, 5'b00101, 3, 0);
    send(32'h7F7FFFFF, 3'b111, RM_RTZ, 0, 0, 0, 32'h7F7FFFFF, 5'b00001, 2, 0);
    send(32'hFF7FFFFF, 3'b111, RM_RDN, 0, 0, 0, 32'hFF800000, 5'b00101, 3, 0);

    // Directed modes.
    send(32'h3F800000, 3'b100, RM_RMM, 0, 0, 0, 32'h3F800001, 5'b00001, 2, 0);
    send(32'hC0000000, 3'b001, RM_RDN, 0, 0, 0, 32'hC0000001, 5'b00001, 2, 0);
    send(32'h40000000, 3'b011, RM_RDN, 0, 0, 0, 32'h40000000, 5'b00001, 2, 0);
    send(32'hBF800000, 3'b010, RM_RUP, 0, 0, 0, 32'hBF800000, 5'b00001, 2, 0);
    send(32'h3F800000, 3'b001, RM_RUP, 0, 0, 0, 32'h3F800001, 5'b00001, 2, 0);
    send(32'h40490FDB, 3'b000, RM_RNE, 0, 0, 0, 32'h40490FDB, 5'b00000, 2, 0);

    // Invalid op / illegal rm, with priority over overflow and underflow.
    send(32'h3F800000, 3'b111, RM_RNE, 1, 0, 1, 32'h7FC00000, 5'b10000, 2, 0);
    send(32'h12345678, 3'b000, 3'b101, 0, 0, 0, 32'h7FC00000, 5'b10000, 2, 0);
    send(32'h3F800000, 3'b000, 3'b111, 0, 1, 0, 32'h7FC00000, 5'b10000, 2, 0);

    // Producer overflow across modes; overflow wins over underflow.
    send(32'hBF800000, 3'b000, RM_RTZ, 1, 0, 0, 32'hFF7FFFFF, 5'b00101, 2, 0);
    send(32'h3F800000, 3'b000, RM_RDN, 1, 0, 0, 32'h7F7FFFFF, 5'b00101, 2, 0);
    send(32'hBF800000, 3'b000, RM_RUP, 1, 0, 0, 32'hFF7FFFFF, 5'b00101, 2, 0);
    send(32'hBF800000, 3'b000, RM_RNE, 1, 0, 0, 32'hFF800000, 5'b00101, 2, 0);
    send(32'h3F800000, 3'b000, RM_RMM, 1, 1, 0, 32'h7F800000, 5'b00101, 2, 0);

    // Inf/NaN pass through untouched.
    send(32'h7F800000, 3'b111, RM_RUP, 0, 0, 0, 32'h7F800000, 5'b00000, 2, 0);
    send(32'hFFC12345, 3'b101, RM_RNE, 0, 0, 0, 32'hFFC12345, 5'b00000, 2, 0);

    // Subnormals.
    send(32'h007FFFFF, 3'b100, RM_RNE, 0, 0, 0, 32'h00800000, 5'b00001, 3, 0);
`ifdef FP_FLUSH_TO_ZERO_EN
    send(32'h00000001, 3'b000, RM_RNE, 0, 0, 0, 32'h00000000, 5'b00011, 2, 0);
    send(32'h00400000, 3'b000, RM_RNE, 0, 1, 0, 32'h00000000, 5'b00011, 2, 0);
    send(32'h00000000, 3'b001, RM_RUP, 0, 0, 0, 32'h00000000, 5'b00011, 2, 0);
`else
    send(32'h00000001, 3'b000, RM_RNE, 0, 0, 0, 32'h00000001, 5'b00000, 2, 0);
    send(32'h00400000, 3'b000, RM_RNE, 0, 1, 0, 32'h00400000, 5'b00010, 2, 0);
    send(32'h00000000, 3'b001, RM_RUP, 0, 0, 0, 32'h00000001, 5'b00011, 2, 0);
`endif

    // Clock enable low for two cycles stretches latency by two.
    send(32'h3F800001, 3'b100, RM_RNE, 0, 0, 0, 32'h3F800002, 5'b00001, 2, 2);

    // Reset while in ROUND aborts the operation.
    @(negedge clk_i);
    to_round = 32'h3F800001; grs = 3'b100; rm = RM_RNE; ovf = 0; udf = 0; inv = 0;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    chk("busy_in_round", 32'(fu_state), 32'(FU_BUSY));
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 chk("abort_fu_state", 32'(fu_state), 32'(FU_FREE));
    chk("abort_valid", 32'(valid_o), 32'd0);
    rst_i = 1'b0;
    repeat (5) @(posedge clk_i);

    // valid_i held through ROUND and VALID: only the first op completes.
    @(negedge clk_i);
    to_round = 32'h3F800000; grs = 3'b000; rm = RM_RNE; valid_i = 1'b1;
    push_exp(32'h3F800000, 5'b00000, 2);
    @(posedge clk_i);
    #1 to_round = 32'h3F7FFFFF; grs = 3'b110;
    repeat (2) @(posedge clk_i);
    #1 valid_i = 1'b0;
    wait_drain();
    repeat (5) @(posedge clk_i);

    chk("valid_count", 32'(n_valid), 32'(n_sent));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
